// File: rtl/int8_mac_instr_pkg.sv
// rtl/int8_mac_instr_pkg.sv - Shared INT8 MAC opcode set and dot-sequencer state encoding
package int8_mac_instr_pkg;

    // Opcodes understood by the shared int8_mac_unit.
    typedef enum logic [2:0] {
        MAC8     = 3'd0,
        MAC8_ACC = 3'd1,
        MUL8     = 3'd2,
        CLIP8    = 3'd3,
        SIMD_DOT = 3'd4,
        ILLEGAL  = 3'd7
    } opcode_t;

    // Dot-product sequencer control states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        EXEC      = 3'd2,
        ACC       = 3'd3,
        CLIP_EXEC = 3'd4,
        CLIP_ACC  = 3'd5,
        RESP      = 3'd6
    } seq_state_e;

endpackage

// File: rtl/int8_dot_sequencer_if.sv
// rtl/int8_dot_sequencer_if.sv - Command, operand-read, MAC and response bundle of the dot sequencer
//   cmd_*  : command valid/ready channel (addresses, length, init, clip, rd tag)
//   mem_*  : two 1-cycle-latency word read ports (A and B operands)
//   mac_*  : operand/opcode issue to and result capture from int8_mac_unit
//   rsp_*  : result valid/ready channel; busy reports a command in flight
//   slave  : sequencer view; master : environment view
interface int8_dot_sequencer_if #(
    parameter int XLEN = 32,
    parameter int AW   = 16,
    parameter int LW   = 12
) ();
    import int8_mac_instr_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_a_addr;
    logic [AW-1:0]   cmd_b_addr;
    logic [LW-1:0]   cmd_len;
    logic [XLEN-1:0] cmd_acc_init;
    logic            cmd_clip;
    logic [4:0]      cmd_rd_addr;

    logic            mem_a_req;
    logic [AW-1:0]   mem_a_addr;
    logic [XLEN-1:0] mem_a_rdata;
    logic            mem_b_req;
    logic [AW-1:0]   mem_b_addr;
    logic [XLEN-1:0] mem_b_rdata;

    opcode_t         mac_opcode;
    logic [XLEN-1:0] mac_rs1;
    logic [XLEN-1:0] mac_rs2;
    logic [XLEN-1:0] mac_rd;
    logic [XLEN-1:0] mac_result;
    logic            mac_valid;
    logic            mac_overflow;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd_addr;
    logic            rsp_overflow;
    logic            rsp_err;
    logic            busy;

    modport slave (
        input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_len, cmd_acc_init, cmd_clip, cmd_rd_addr,
        output cmd_ready,
        output mem_a_req, mem_a_addr, mem_b_req, mem_b_addr,
        input  mem_a_rdata, mem_b_rdata,
        output mac_opcode, mac_rs1, mac_rs2, mac_rd,
        input  mac_result, mac_valid, mac_overflow,
        output rsp_valid, rsp_data, rsp_rd_addr, rsp_overflow, rsp_err, busy,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_len, cmd_acc_init, cmd_clip, cmd_rd_addr,
        input  cmd_ready,
        input  mem_a_req, mem_a_addr, mem_b_req, mem_b_addr,
        output mem_a_rdata, mem_b_rdata,
        input  mac_opcode, mac_rs1, mac_rs2, mac_rd,
        output mac_result, mac_valid, mac_overflow,
        input  rsp_valid, rsp_data, rsp_rd_addr, rsp_overflow, rsp_err, busy,
        output rsp_ready
    );

endinterface

// File: rtl/int8_dot_sequencer.sv
// rtl/int8_dot_sequencer.sv - Command-driven long INT8 dot product on the shared MAC unit
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (aborts any command in flight)
//   bus    : int8_dot_sequencer_if.slave (command, operand reads, MAC issue, response)
module int8_dot_sequencer
    import int8_mac_instr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 16,
    parameter int LW   = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    int8_dot_sequencer_if.slave bus
);

    seq_state_e      state;
    logic [AW-1:0]   a_ptr;
    logic [AW-1:0]   b_ptr;
    logic [LW-1:0]   remaining;
    logic            clip_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] acc;
    logic            ovf_q;
    logic            err_q;
    logic            cmd_ready_q;
    logic            busy_q;
    logic            mem_req_q;
    logic            rsp_valid_q;
    opcode_t         opcode_q;

    // Control outputs are registered: each transition sets the outputs
    // belonging to the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            a_ptr       <= '0;
            b_ptr       <= '0;
            remaining   <= '0;
            clip_q      <= 1'b0;
            rd_addr_q   <= '0;
            acc         <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            opcode_q    <= ILLEGAL;
        end else begin
            mem_req_q <= 1'b0;
            opcode_q  <= ILLEGAL;
            unique case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        a_ptr       <= bus.cmd_a_addr;
                        b_ptr       <= bus.cmd_b_addr;
                        remaining   <= bus.cmd_len;
                        clip_q      <= bus.cmd_clip;
                        rd_addr_q   <= bus.cmd_rd_addr;
                        acc         <= bus.cmd_acc_init;
                        ovf_q       <= 1'b0;
                        err_q       <= 1'b0;
                        if (bus.cmd_len != '0) begin
                            state     <= FETCH;
                            mem_req_q <= 1'b1;
                        end else if (bus.cmd_clip) begin
                            state    <= CLIP_EXEC;
                            opcode_q <= CLIP8;
                        end else begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state    <= EXEC;
                    opcode_q <= SIMD_DOT;
                end
                EXEC: begin
                    state <= ACC;
                end
                ACC: begin
                    acc       <= bus.mac_result;
                    ovf_q     <= ovf_q | bus.mac_overflow;
                    if (!bus.mac_valid) begin
                        err_q <= 1'b1;
                    end
                    a_ptr     <= a_ptr + AW'(1);
                    b_ptr     <= b_ptr + AW'(1);
                    remaining <= remaining - LW'(1);
                    if (remaining != LW'(1)) begin
                        state     <= FETCH;
                        mem_req_q <= 1'b1;
                    end else if (clip_q) begin
                        state    <= CLIP_EXEC;
                        opcode_q <= CLIP8;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                CLIP_EXEC: begin
                    state <= CLIP_ACC;
                end
                CLIP_ACC: begin
                    acc   <= bus.mac_result;
                    ovf_q <= ovf_q | bus.mac_overflow;
                    if (!bus.mac_valid) begin
                        err_q <= 1'b1;
                    end
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.busy         = busy_q;

    // Addresses are only presented while the read strobe is up.
    assign bus.mem_a_req    = mem_req_q;
    assign bus.mem_b_req    = mem_req_q;
    assign bus.mem_a_addr   = mem_req_q ? a_ptr : '0;
    assign bus.mem_b_addr   = mem_req_q ? b_ptr : '0;

    // Operand read data arrives during EXEC, one cycle after the strobe, so
    // the MAC operands are steered straight from the read ports in that state.
    assign bus.mac_opcode   = opcode_q;
    assign bus.mac_rs1      = (state == EXEC)      ? bus.mem_a_rdata :
                              (state == CLIP_EXEC) ? acc : '0;
    assign bus.mac_rs2      = (state == EXEC)      ? bus.mem_b_rdata : '0;
    assign bus.mac_rd       = (state == EXEC)      ? acc : '0;

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = acc;
    assign bus.rsp_rd_addr  = rd_addr_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_err      = err_q;

endmodule

// File: doc/int8_dot_sequencer.md
Name: int8_dot_sequencer

Overview:
Command-driven controller that computes long INT8 dot products on the shared int8_mac_unit. It fetches packed 4xINT8 operand words from two 1-cycle-latency read ports and issues one SIMD_DOT per word, feeding the running 32-bit accumulator back through the unit's rd operand. It can optionally finish with a CLIP8 pass and returns the result, destination register and a sticky overflow flag on a valid/ready response port.

Parameters:
XLEN, 32, data width; must equal the MAC unit XLEN (4 packed INT8 lanes).
AW, 16, word-address width of both operand read ports.
LW, 12, width of the length field (max words = 2^LW-1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_a_addr_i  in  AW  start word address, operand A
cmd_b_addr_i  in  AW  start word address, operand B
cmd_len_i  in  LW  number of words
cmd_acc_init_i  in  XLEN  initial accumulator
cmd_clip_i  in  1  apply CLIP8 to the final sum
cmd_rd_addr_i  in  5  destination register tag
mem_a_req_o / mem_b_req_o  out  1  read strobes
mem_a_addr_o / mem_b_addr_o  out  AW  read addresses
mem_a_rdata_i / mem_b_rdata_i  in  XLEN  read data, valid exactly 1 cycle after req
mac_opcode_o  out  opcode_t  MAC opcode (SIMD_DOT, CLIP8, ILLEGAL when idle)
mac_rs1_o, mac_rs2_o, mac_rd_o  out  XLEN  MAC operands
mac_result_i  in  XLEN  MAC registered result
mac_valid_i  in  1  MAC valid
mac_overflow_i  in  1  MAC overflow
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result consumed
rsp_data_o  out  XLEN  final accumulator
rsp_rd_addr_o  out  5  latched cmd_rd_addr_i
rsp_overflow_o  out  1  sticky overflow over the whole command
rsp_err_o  out  1  MAC valid missing in an ACC cycle
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, mac_opcode_o=ILLEGAL, state IDLE, internal registers 0. An rst_ni assertion mid-command aborts it; no response is produced.
- States: IDLE, FETCH, EXEC, ACC, CLIP_EXEC, CLIP_ACC, RESP.
- IDLE: cmd_ready_o=1. On handshake, latch addresses, len, clip, rd_addr; acc<=cmd_acc_init_i; ovf<=0; err<=0. Next state is FETCH if len!=0, else CLIP_EXEC if clip, else RESP.
- FETCH: both req=1, addr=current pointers. -> EXEC.
- EXEC: opcode=SIMD_DOT, rs1=mem_a_rdata_i, rs2=mem_b_rdata_i, rd=acc. -> ACC.
- ACC: opcode=ILLEGAL. acc<=mac_result_i; ovf|=mac_overflow_i; if !mac_valid_i then err<=1. Pointers +1, wrapping modulo 2^AW. remaining-1. Next is FETCH if remaining!=1; otherwise CLIP_EXEC if clip, else RESP.
- CLIP_EXEC: opcode=CLIP8, rs1=acc, rs2=0, rd=0. -> CLIP_ACC, which captures like ACC. -> RESP.
- RESP: rsp_valid_o=1, holding data, rd_addr, overflow and err stable until rsp_ready_i. On the handshake -> IDLE. cmd_ready_o=0 (no command overlap).
- Timing from the handshake at cycle 0: rsp_valid_o rises at cycle 3*len+1, plus 2 cycles if clip. len=0 without clip gives rsp_valid_o at cycle 1.
- Outside EXEC and CLIP_EXEC, mac_rs*/rd = 0 and opcode=ILLEGAL, so the MAC unit never raises valid_o spuriously.
- Accumulation wraps at 32 bits. The MAC SIMD_DOT does not saturate, and the sequencer adds no saturation of its own.
- The sequencer owns the MAC unit exclusively; hartid/id are tied off by the integrator.

Decomposition:
- int8_mac_instr_pkg supplies opcode_t (MAC8, MAC8_ACC, MUL8, CLIP8, SIMD_DOT, ILLEGAL).
- Add a seq_state_e enum to that package.
- No sub-module; the MAC unit is instantiated beside this block in the tile wrapper, not inside it.
- The bench wraps sequencer + int8_mac_unit + two behavioural ROMs.

Test Plan:
1. Single word: A=0x01010101, B=0x02020202, len=1, init=0, no clip -> rsp_data=8, rsp_valid at cycle 4, overflow=0, err=0.
2. Four words of A=0x7F7F7F7F, B=0x7F7F7F7F, init=5 -> 4*64516+5=258069 (0x0003F015), rsp_valid at cycle 13.
3. Clip path: A=0x80808080, B=0x7F7F7F7F, len=1, clip=1 -> sum=-65024, rsp_data=0xFFFFFF80, overflow=1, rsp_valid at cycle 6.
4. len=0, init=0x12345678, clip=0 -> rsp_data=0x12345678 at cycle 1, no mem_*_req pulses.
5. Address wrap: a_addr=0xFFFF, len=2 -> second read at address 0x0000; hold rsp_ready_i=0 for 5 cycles -> outputs stable and cmd_ready_o=0 throughout.
6. Reset asserted during EXEC -> all outputs return to reset values, no rsp_valid; the next command completes normally. Forcing mac_valid_i low in ACC -> rsp_err_o=1.
